// File: rtl/dual_result_checker.sv
// dual_result_checker
//   Captures the two-beat done frame produced by the dual-multiplier stage
//   (beat 0 = multiplier-1 product A, beat 1 = multiplier-2 product B),
//   compares the redundant products and presents product A plus a mismatch
//   flag through a valid/ack handshake. It also keeps sticky error status and
//   a saturating mismatch counter.
//
// Parameters
//   NAN_EQUIV : 1 -> any two NaNs compare equal; 0 -> strictly bitwise compare
//   COUNT_W   : width of the saturating mismatch counter
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   in_done       : upstream done, high for the two beats of a frame
//   in_res[31:0]  : upstream result (beat 0 = A, beat 1 = B)
//   out_valid     : out_res / out_mismatch hold a checked frame
//   out_ack       : downstream accepts the frame while out_valid = 1
//   out_res[31:0] : product A of the checked frame
//   out_mismatch  : A and B differed under the compare rule
//   err_count     : saturating count of mismatched frames
//   frame_err     : sticky, done pulse was 1 beat or longer than 2 beats
//   overflow      : sticky, a checked frame was dropped (output register full)
//   clr_err       : synchronous clear of err_count, frame_err and overflow
module dual_result_checker #(
  parameter bit NAN_EQUIV = 1'b1,
  parameter int COUNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_done,
  input  logic [31:0]        in_res,
  output logic               out_valid,
  input  logic               out_ack,
  output logic [31:0]        out_res,
  output logic               out_mismatch,
  output logic [COUNT_W-1:0] err_count,
  output logic               frame_err,
  output logic               overflow,
  input  logic               clr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP2 = 2'd1,
    CMP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        prev_done;
  logic [31:0] res_a;
  logic [31:0] res_b;

  // FSM strobes
  logic cap_a;
  logic cap_b;
  logic do_cmp;
  logic bad_frame;

  logic frame_start;
  logic equal;
  logic out_free;
  logic load_out;
  logic drop_out;
  logic mismatch_evt;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // A frame only starts on the rising edge of done, so a done level that is
  // still high after a third beat is never mistaken for a new frame.
  assign frame_start = in_done & ~prev_done;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (frame_start) state_nxt = CAP2;
      CAP2:    state_nxt = in_done ? CMP : IDLE;
      CMP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    do_cmp    = 1'b0;
    bad_frame = 1'b0;
    unique case (state)
      IDLE: cap_a = frame_start;
      CAP2: begin
        cap_b     = in_done;
        bad_frame = ~in_done;   // single-beat pulse
      end
      CMP: begin
        do_cmp    = 1'b1;
        bad_frame = in_done;    // third beat
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_done <= 1'b0;
      res_a     <= '0;
      res_b     <= '0;
    end else begin
      prev_done <= in_done;
      if (cap_a) res_a <= in_res;
      if (cap_b) res_b <= in_res;
    end
  end

  // ---------------------------------------------------------------- compare
  assign equal        = (res_a == res_b) ||
                        (NAN_EQUIV && is_nan(res_a) && is_nan(res_b));
  assign out_free     = ~out_valid | out_ack;
  assign load_out     = do_cmp & out_free;
  assign drop_out     = do_cmp & ~out_free;
  assign mismatch_evt = do_cmp & ~equal;

  // ---------------------------------------------------------------- output
  // A new frame may load in the same cycle the previous one is acked, which
  // keeps out_valid high across back-to-back transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_res      <= '0;
      out_mismatch <= 1'b0;
    end else if (load_out) begin
      out_valid    <= 1'b1;
      out_res      <= res_a;
      out_mismatch <= ~equal;
    end else if (out_ack) begin
      out_valid    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- status
  // A new error event takes priority over clr_err in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (mismatch_evt) begin
        if (clr_err)                err_count <= COUNT_W'(1);
        else if (err_count != '1)   err_count <= err_count + COUNT_W'(1);
      end else if (clr_err) begin
        err_count <= '0;
      end

      if (bad_frame)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;

      if (drop_out)     overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dual_result_checker.sv
// Testbench for dual_result_checker. Two instances share all inputs: u0 uses
// NAN_EQUIV=1 / COUNT_W=8, u1 uses NAN_EQUIV=0 / COUNT_W=2. A reference model
// tracks frames in beats and pushes each accepted frame onto a scoreboard;
// a monitor on the falling edge compares the DUT outputs against it.
module tb_dual_result_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_done = 1'b0;
  logic [31:0] in_res = '0;
  logic        out_ack = 1'b0;
  logic        clr_err = 1'b0;

  logic        out_valid0, out_mismatch0, frame_err0, overflow0;
  logic [31:0] out_res0;
  logic [7:0]  err_count0;
  logic        out_valid1, out_mismatch1, frame_err1, overflow1;
  logic [31:0] out_res1;
  logic [1:0]  err_count1;

  dual_result_checker #(.NAN_EQUIV(1'b1), .COUNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_done(in_done), .in_res(in_res),
    .out_valid(out_valid0), .out_ack(out_ack), .out_res(out_res0),
    .out_mismatch(out_mismatch0), .err_count(err_count0),
    .frame_err(frame_err0), .overflow(overflow0), .clr_err(clr_err)
  );

  dual_result_checker #(.NAN_EQUIV(1'b0), .COUNT_W(2)) u1 (
    .clk(clk), .rst(rst), .in_done(in_done), .in_res(in_res),
    .out_valid(out_valid1), .out_ack(out_ack), .out_res(out_res1),
    .out_mismatch(out_mismatch1), .err_count(err_count1),
    .frame_err(frame_err1), .overflow(overflow1), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  bit rand_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 0);
  endfunction

  function automatic bit same(input logic [31:0] a, input logic [31:0] b, input bit nan_eq);
    return (a == b) || (nan_eq && is_nan(a) && is_nan(b));
  endfunction

  // ------------------------------------------------------------ reference model
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } frame_t;

  frame_t      sb[$];
  int          m_beats = 0;     // beats of the current frame seen so far (2 = compare cycle)
  bit          m_prev  = 0;
  bit          m_full  = 0;     // output register holds an un-acked frame
  bit          m_ferr  = 0;
  bit          m_ovf   = 0;
  int          m_cnt0  = 0;
  int          m_cnt1  = 0;
  logic [31:0] m_a, m_b;
  bit          ferr_evt, ovf_evt, mm0, mm1;
  frame_t      fr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_beats = 0; m_prev = 0; m_full = 0; m_ferr = 0; m_ovf = 0;
      m_cnt0 = 0; m_cnt1 = 0;
      sb.delete();
    end else begin
      ferr_evt = 0; ovf_evt = 0; mm0 = 0; mm1 = 0;
      if (m_beats == 2) begin
        if (!m_full || out_ack) begin
          fr.a = m_a; fr.b = m_b;
          sb.push_back(fr);
          m_full = 1;
        end else begin
          ovf_evt = 1;
        end
        mm0 = !same(m_a, m_b, 1'b1);
        mm1 = !same(m_a, m_b, 1'b0);
        if (in_done) ferr_evt = 1;
      end else if (m_full && out_ack) begin
        m_full = 0;
      end
      if (m_beats == 1 && !in_done) ferr_evt = 1;

      if (mm0)          m_cnt0 = clr_err ? 1 : (m_cnt0 < 255 ? m_cnt0 + 1 : 255);
      else if (clr_err) m_cnt0 = 0;
      if (mm1)          m_cnt1 = clr_err ? 1 : (m_cnt1 < 3 ? m_cnt1 + 1 : 3);
      else if (clr_err) m_cnt1 = 0;
      if (ferr_evt)     m_ferr = 1; else if (clr_err) m_ferr = 0;
      if (ovf_evt)      m_ovf  = 1; else if (clr_err) m_ovf  = 0;

      case (m_beats)
        0: if (in_done && !m_prev) begin m_a = in_res; m_beats = 1; end
        1: if (in_done) begin m_b = in_res; m_beats = 2; end else m_beats = 0;
        default: m_beats = 0;
      endcase
      m_prev = in_done;
    end
  end

  // ------------------------------------------------------------ monitor
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid0", 32'(out_valid0), 32'(m_full));
      check("out_valid1", 32'(out_valid1), 32'(m_full));
      if (m_full && sb.size() > 0) begin
        check("out_res0",      out_res0, sb[0].a);
        check("out_res1",      out_res1, sb[0].a);
        check("out_mismatch0", 32'(out_mismatch0), 32'(!same(sb[0].a, sb[0].b, 1'b1)));
        check("out_mismatch1", 32'(out_mismatch1), 32'(!same(sb[0].a, sb[0].b, 1'b0)));
        if (out_ack) void'(sb.pop_front());
      end
      check("err_count0", 32'(err_count0), 32'(m_cnt0));
      check("err_count1", 32'(err_count1), 32'(m_cnt1));
      check("frame_err0", 32'(frame_err0), 32'(m_ferr));
      check("frame_err1", 32'(frame_err1), 32'(m_ferr));
      check("overflow0",  32'(overflow0),  32'(m_ovf));
      check("overflow1",  32'(overflow1),  32'(m_ovf));
    end
  end

  // ------------------------------------------------------------ stimulus
  // Inputs change 1 time unit after a rising edge and are sampled at the next.
  task automatic drive(input bit d, input logic [31:0] v);
    in_done = d;
    in_res  = v;
    if (rand_mode) begin
      out_ack = ($urandom_range(0, 9) < 6);
      clr_err = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0);
  endtask

  task automatic frame(input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, a);
    drive(1'b1, b);
    drive(1'b0, 32'h0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},  32'(out_valid0),    32'h0);
    check({tag, "_res"},    out_res0,           32'h0);
    check({tag, "_mm"},     32'(out_mismatch0), 32'h0);
    check({tag, "_cnt"},    32'(err_count0),    32'h0);
    check({tag, "_ferr"},   32'(frame_err0),    32'h0);
    check({tag, "_ovf"},    32'(overflow0),     32'h0);
    check({tag, "_res1"},   out_res1,           32'h0);
    check({tag, "_cnt1"},   32'(err_count1),    32'h0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] vals [8];
    vals[0] = 32'h40C00000; vals[1] = 32'h40C00001; vals[2] = 32'h7FC00000;
    vals[3] = 32'h7F800001; vals[4] = 32'h7F800000; vals[5] = 32'h00000000;
    vals[6] = 32'h80000000; vals[7] = 32'hFF800001;
    return vals[$urandom_range(0, 7)];
  endfunction

  initial begin
    logic [31:0] a, b;
    int len, r;

    // reset
    #1 rst = 1'b1;
    #1 check_zero_outputs("reset");
    mon_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // clean frame, ack held
    out_ack = 1'b1;
    frame(32'h40C00000, 32'h40C00000);
    idle(2);

    // mismatch, clear while not acked, then ack
    out_ack = 1'b0;
    frame(32'h40C00000, 32'h40C00001);
    idle(1);
    clr_err = 1'b1; idle(1); clr_err = 1'b0;
    idle(2);
    out_ack = 1'b1;
    idle(2);

    // NaN pair: equal under u0, mismatch under u1
    frame(32'h7FC00000, 32'h7F800001);
    idle(2);

    // signed zeros
    frame(32'h00000000, 32'h80000000);
    idle(2);

    // one-beat pulse, then three-beat pulse
    drive(1'b1, 32'h40000000);
    idle(3);
    clr_err = 1'b1; idle(1); clr_err = 1'b0;
    drive(1'b1, 32'h3F800000);
    drive(1'b1, 32'h3F800000);
    drive(1'b1, 32'h40000000);
    idle(3);

    // backpressure: second frame dropped
    clr_err = 1'b1; idle(1); clr_err = 1'b0;
    out_ack = 1'b0;
    frame(32'h3F800000, 32'h3F800000);
    frame(32'h40000000, 32'h40000000);
    idle(3);
    out_ack = 1'b1;
    idle(3);

    // saturation: 4 mismatched frames (u1 saturates at 3)
    clr_err = 1'b1; idle(1); clr_err = 1'b0;
    repeat (4) frame(32'h40C00000, 32'h40C00001);
    idle(2);

    // reset between beat 0 and beat 1, then a clean frame
    drive(1'b1, 32'h3F800000);
    in_done = 1'b0;
    rst = 1'b1;
    #1 check_zero_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    frame(32'h3F800000, 32'h3F800000);
    idle(2);

    // randomized frames with random ack / clear
    rand_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      a = pick();
      b = ($urandom_range(0, 1) == 1) ? a : pick();
      r = $urandom_range(0, 99);
      len = (r < 70) ? 2 : (r < 85) ? 1 : 3;
      drive(1'b1, a);
      if (len >= 2) drive(1'b1, b);
      if (len >= 3) drive(1'b1, pick());
      idle($urandom_range(1, 3));
    end
    rand_mode = 1'b0;
    out_ack = 1'b1;
    clr_err = 1'b0;
    idle(4);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
